data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp_pkg.sv | 32 +++
 rtl/data_mem_resp_dmem_array.sv | 28 ++
 rtl/data_mem_resp.sv | 135 +++++++++++++
 tb/tb_data_mem_resp.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/data_mem_resp_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// word-offset width and the address-check error reasons.
package data_mem_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int unsigned WORD_OFS_W = 2;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } err_reason_e;

  // Misalignment takes priority over range so the reason reflects the first fault seen.
  function automatic err_reason_e check_addr(input logic [31:0] adr, input int unsigned depth);
    err_reason_e reason;
    if (adr[WORD_OFS_W-1:0] != 2'b00) begin
      reason = ERR_MISALIGN;
    end else if ({2'b00, adr[31:WORD_OFS_W]} >= 32'(depth)) begin
      reason = ERR_RANGE;
    end else begin
      reason = ERR_NONE;
    end
    return reason;
  endfunction

endpackage

// File: rtl/data_mem_resp_dmem_array.sv
// Word storage for the data-memory responder: synchronous write, combinational read,
// no reset so contents survive a system reset.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic        w_in_range;

  assign w_in_range = ({{(32-AW){1'b0}}, i_addr} < 32'(DEPTH_WORDS));

  // Word write port.
  always_ff @(posedge clk) begin
    if (i_we && w_in_range) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = w_in_range ? r_mem[i_addr] : 32'd0;

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: accepts one lw/sw request at a time, inserts WAIT_CYCLES
// wait states, then returns a one-cycle ack with registered rdata/err.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_wdata;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_idle;
  logic        w_accept;
  logic        w_enter_resp;
  logic        w_cur_we;
  logic [31:0] w_cur_adr;
  logic [31:0] w_cur_wdata;
  logic        w_cur_err;
  logic        w_mem_we;
  logic [31:0] w_mem_rdata;

  // With zero wait states RESP is entered on the capture edge, so the live inputs
  // must stand in for the latched request until the latch has been loaded.
  assign w_idle       = (r_state == S_IDLE);
  assign w_accept     = w_idle & req;
  assign w_cur_we     = w_idle ? we    : r_we;
  assign w_cur_adr    = w_idle ? adr   : r_adr;
  assign w_cur_wdata  = w_idle ? wdata : r_wdata;
  assign w_cur_err    = (check_addr(w_cur_adr, DEPTH_WORDS) != ERR_NONE);
  assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);
  assign w_mem_we     = rst_n & w_enter_resp & w_cur_we & ~w_cur_err;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_dmem_array (
    .clk    (clk),
    .i_we   (w_mem_we),
    .i_addr (w_cur_adr[WORD_OFS_W +: AW]),
    .i_wdata(w_cur_wdata),
    .o_rdata(w_mem_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Wait counter and request latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_adr   <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_cnt   <= WAIT_INIT;
      r_we    <= we;
      r_adr   <= adr;
      r_wdata <= wdata;
    end else if (r_state == S_WAIT) begin
      r_cnt   <= r_cnt - 4'd1;
    end else begin
      r_cnt   <= 4'd0;
    end
  end

  // Response registers: loaded on the edge entering RESP, cleared otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ack   <= w_enter_resp;
      r_err   <= w_enter_resp & w_cur_err;
      r_rdata <= (w_enter_resp && !w_cur_we && !w_cur_err) ? w_mem_rdata : 32'd0;
    end
  end

  assign ack   = r_ack;
  assign err   = r_err;
  assign rdata = r_rdata;
  assign busy  = ~w_idle;

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed self-checking bench for data_mem_resp (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] adr = 32'd0, wdata = 32'd0;
  logic        ack, err, busy;
  logic [31:0] rdata;
  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] adr1 = 32'd0, wdata1 = 32'd0;
  logic        ack1, err1, busy1;
  logic [31:0] rdata1;

  int n_tests = 0;
  int n_fail  = 0;
  int          lat;
  logic [31:0] rd;
  logic        er;
  int          n_extra;

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .adr(adr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy)
  );

  data_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .adr(adr1), .wdata(wdata1),
    .ack(ack1), .rdata(rdata1), .err(err1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single edge, then waits (bounded) for ack.
  // Returns with time just after the edge that ends the RESP cycle.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output int l, output logic [31:0] r, output logic e);
    @(negedge clk);
    req = 1'b1; we = w; adr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; adr = 32'd0; wdata = 32'd0;
    l = 1;
    while (!ack && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
    if (!ack) l = -1;
    r = rdata;
    e = err;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_ack",   {31'd0, ack},  32'd0);
    chk("rst_err",   {31'd0, err},  32'd0);
    chk("rst_rdata", rdata,         32'd0);
    rst_n = 1'b1;

    // Write then read 0x10
    txn(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
    chk("wr10_lat",   32'(lat),     32'd3);
    chk("wr10_err",   {31'd0, er},  32'd0);
    chk("wr10_rdata", rd,           32'd0);
    chk("wr10_ackdrop", {31'd0, ack}, 32'd0);
    chk("wr10_idle",  {31'd0, busy}, 32'd0);
    txn(1'b0, 32'h10, 32'd0, lat, rd, er);
    chk("rd10_lat",   32'(lat),     32'd3);
    chk("rd10_rdata", rd,           32'hDEADBEEF);
    chk("rd10_err",   {31'd0, er},  32'd0);
    chk("rd10_rdata_after", rdata,  32'd0);

    // Misaligned write must not touch storage
    txn(1'b1, 32'h13, 32'hCAFEF00D, lat, rd, er);
    chk("wr13_lat",   32'(lat),     32'd3);
    chk("wr13_err",   {31'd0, er},  32'd1);
    chk("wr13_rdata", rd,           32'd0);
    chk("err_clear",  {31'd0, err}, 32'd0);
    txn(1'b0, 32'h10, 32'd0, lat, rd, er);
    chk("rd10b_rdata", rd,          32'hDEADBEEF);

    // Range boundaries: last word valid, 0x400 out of range with no wrap to word 0
    txn(1'b1, 32'h3FC, 32'h0BADCAFE, lat, rd, er);
    chk("wr3fc_err",  {31'd0, er},  32'd0);
    txn(1'b1, 32'h0,   32'h11111111, lat, rd, er);
    txn(1'b0, 32'h400, 32'd0, lat, rd, er);
    chk("rd400_lat",  32'(lat),     32'd3);
    chk("rd400_err",  {31'd0, er},  32'd1);
    chk("rd400_rdata", rd,          32'd0);
    txn(1'b1, 32'h400, 32'h22222222, lat, rd, er);
    chk("wr400_err",  {31'd0, er},  32'd1);
    txn(1'b0, 32'h0, 32'd0, lat, rd, er);
    chk("rd0_rdata",  rd,           32'h11111111);
    txn(1'b0, 32'h3FC, 32'd0, lat, rd, er);
    chk("rd3fc_rdata", rd,          32'h0BADCAFE);
    chk("rd3fc_err",  {31'd0, er},  32'd0);

    // Request pulsed mid-WAIT is ignored
    txn(1'b1, 32'h20, 32'h00000055, lat, rd, er);
    @(negedge clk);
    req = 1'b1; we = 1'b0; adr = 32'h10; wdata = 32'd0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; adr = 32'h20; wdata = 32'h00000BAD;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; adr = 32'd0; wdata = 32'd0;
    chk("mid_noack", {31'd0, ack}, 32'd0);
    @(posedge clk); #1;
    chk("mid_ack",   {31'd0, ack}, 32'd1);
    chk("mid_rdata", rdata,        32'hDEADBEEF);
    n_extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) n_extra++;
    end
    chk("mid_single_ack", 32'(n_extra), 32'd0);
    txn(1'b0, 32'h20, 32'd0, lat, rd, er);
    chk("rd20_rdata", rd, 32'h00000055);

    // Reset during WAIT discards the pending write
    txn(1'b1, 32'h8, 32'hA5A5A5A5, lat, rd, er);
    @(negedge clk);
    req = 1'b1; we = 1'b1; adr = 32'h8; wdata = 32'h00001234;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; adr = 32'd0; wdata = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_ack",  {31'd0, ack},  32'd0);
    n_extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ack) n_extra++;
    end
    chk("rstw_never_ack", 32'(n_extra), 32'd0);
    rst_n = 1'b1;
    txn(1'b0, 32'h8, 32'd0, lat, rd, er);
    chk("rd8_lat",   32'(lat), 32'd3);
    chk("rd8_rdata", rd,       32'hA5A5A5A5);

    // Reset during RESP keeps the committed write
    @(negedge clk);
    req = 1'b1; we = 1'b1; adr = 32'hC; wdata = 32'h00000077;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; adr = 32'd0; wdata = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstr_ack", {31'd0, ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstr_ackclr", {31'd0, ack}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    txn(1'b0, 32'hC, 32'd0, lat, rd, er);
    chk("rdC_rdata", rd, 32'h00000077);

    // Zero wait states, back-to-back write/read with req held high
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; adr1 = 32'h4; wdata1 = 32'h600DF00D;
    @(posedge clk); #1;
    chk("w0_wr_ack",   {31'd0, ack1}, 32'd1);
    chk("w0_wr_rdata", rdata1,        32'd0);
    chk("w0_wr_err",   {31'd0, err1}, 32'd0);
    we1 = 1'b0; wdata1 = 32'd0;
    @(posedge clk); #1;
    chk("w0_gap_ack",  {31'd0, ack1},  32'd0);
    chk("w0_gap_busy", {31'd0, busy1}, 32'd0);
    @(posedge clk); #1;
    req1 = 1'b0; adr1 = 32'd0;
    chk("w0_rd_ack",   {31'd0, ack1}, 32'd1);
    chk("w0_rd_rdata", rdata1,        32'h600DF00D);
    chk("w0_rd_err",   {31'd0, err1}, 32'd0);
    @(posedge clk); #1;
    chk("w0_ackdrop",  {31'd0, ack1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
